// File: rtl/m_stage.sv
// rtl/m_stage.sv - memory stage: word data memory plus M/WB pipeline register (optional MEM_MISALIGN_TRAP_EN)
module m_stage #(
    parameter int ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [31:0]       i_ex_m_alu_result,
    input  logic [31:0]       i_ex_m_write_data,
    input  logic [4:0]        i_ex_m_rd,
    input  logic              i_ex_m_mem_read,
    input  logic              i_ex_m_mem_write,
    input  logic              i_ex_m_mem_to_reg,
    input  logic              i_ex_m_reg_write,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [31:0]       o_dbg_data,
    output logic [31:0]       o_m_wb_alu_result,
    output logic [31:0]       o_m_wb_read_data,
    output logic [4:0]        o_m_wb_rd,
    output logic              o_m_wb_mem_to_reg,
    output logic              o_m_wb_reg_write,
    output logic [31:0]       o_m_wb_data_write
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              o_misaligned
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              misaligned;
    logic              mem_we;

    // Upper address bits are dropped, so accesses wrap around the memory.
    assign idx = i_ex_m_alu_result[ADDR_W+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = (i_ex_m_mem_read | i_ex_m_mem_write) &&
                        (i_ex_m_alu_result[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign mem_we = i_ex_m_mem_write & ~misaligned;

    // Memory has no reset; a store landing while reset is held is dropped.
    always_ff @(posedge i_clk) begin
        if (i_reset && mem_we) begin
            mem[idx] <= i_ex_m_write_data;
        end
    end

    // Non-blocking read sees the pre-write word, giving read-before-write.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_m_wb_alu_result <= '0;
            o_m_wb_read_data  <= '0;
            o_m_wb_rd         <= '0;
            o_m_wb_mem_to_reg <= 1'b0;
            o_m_wb_reg_write  <= 1'b0;
        end else begin
            o_m_wb_alu_result <= i_ex_m_alu_result;
            o_m_wb_read_data  <= i_ex_m_mem_read ? mem[idx] : 32'h0;
            o_m_wb_rd         <= i_ex_m_rd;
            o_m_wb_mem_to_reg <= i_ex_m_mem_to_reg;
            o_m_wb_reg_write  <= i_ex_m_reg_write & ~misaligned;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_misaligned <= 1'b0;
        end else begin
            o_misaligned <= misaligned;
        end
    end
`endif

    assign o_m_wb_data_write = o_m_wb_mem_to_reg ? o_m_wb_read_data : o_m_wb_alu_result;
    assign o_dbg_data        = mem[i_dbg_addr];

endmodule

// File: tb/tb_m_stage.sv
// tb/tb_m_stage.sv - scoreboard bench for m_stage (handles MEM_MISALIGN_TRAP_EN builds too)
module tb_m_stage;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b0;
    logic [31:0]       i_ex_m_alu_result = '0;
    logic [31:0]       i_ex_m_write_data = '0;
    logic [4:0]        i_ex_m_rd = '0;
    logic              i_ex_m_mem_read = 1'b0;
    logic              i_ex_m_mem_write = 1'b0;
    logic              i_ex_m_mem_to_reg = 1'b0;
    logic              i_ex_m_reg_write = 1'b0;
    logic [ADDR_W-1:0] i_dbg_addr = '0;
    logic [31:0]       o_dbg_data;
    logic [31:0]       o_m_wb_alu_result;
    logic [31:0]       o_m_wb_read_data;
    logic [4:0]        o_m_wb_rd;
    logic              o_m_wb_mem_to_reg;
    logic              o_m_wb_reg_write;
    logic [31:0]       o_m_wb_data_write;
    logic              mis_obs;
`ifdef MEM_MISALIGN_TRAP_EN
    logic              o_misaligned;
    assign mis_obs = o_misaligned;
`else
    assign mis_obs = 1'b0;
`endif

    m_stage #(.ADDR_W(ADDR_W)) dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_ex_m_alu_result (i_ex_m_alu_result),
        .i_ex_m_write_data (i_ex_m_write_data),
        .i_ex_m_rd         (i_ex_m_rd),
        .i_ex_m_mem_read   (i_ex_m_mem_read),
        .i_ex_m_mem_write  (i_ex_m_mem_write),
        .i_ex_m_mem_to_reg (i_ex_m_mem_to_reg),
        .i_ex_m_reg_write  (i_ex_m_reg_write),
        .i_dbg_addr        (i_dbg_addr),
        .o_dbg_data        (o_dbg_data),
        .o_m_wb_alu_result (o_m_wb_alu_result),
        .o_m_wb_read_data  (o_m_wb_read_data),
        .o_m_wb_rd         (o_m_wb_rd),
        .o_m_wb_mem_to_reg (o_m_wb_mem_to_reg),
        .o_m_wb_reg_write  (o_m_wb_reg_write),
        .o_m_wb_data_write (o_m_wb_data_write)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .o_misaligned      (o_misaligned)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        m2r;
        logic        rw;
        logic [31:0] dw;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic dbg_check(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        i_dbg_addr = a;
        #1;
        check(tag, o_dbg_data, exp);
    endtask

    // Drive one transaction, push its expected M/WB result, then compare after the edge.
    task automatic step(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                        input logic mr, input logic mw, input logic m2r, input logic rw);
        exp_t               e;
        exp_t               g;
        logic [ADDR_W-1:0]  ix;
        logic               mis;
        ix  = alu[ADDR_W+1:2];
`ifdef MEM_MISALIGN_TRAP_EN
        mis = (mr | mw) && (alu[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        i_ex_m_alu_result = alu;
        i_ex_m_write_data = wd;
        i_ex_m_rd         = rd;
        i_ex_m_mem_read   = mr;
        i_ex_m_mem_write  = mw;
        i_ex_m_mem_to_reg = m2r;
        i_ex_m_reg_write  = rw;
        e.alu   = alu;
        e.rdata = mr ? model[ix] : 32'h0;
        e.rd    = rd;
        e.m2r   = m2r;
        e.rw    = rw & ~mis;
        e.dw    = m2r ? e.rdata : alu;
        e.mis   = mis;
        if (mw && !mis) model[ix] = wd;
        sb.push_back(e);
        @(posedge i_clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            g = sb.pop_front();
            check("alu_result", o_m_wb_alu_result, g.alu);
            check("read_data", o_m_wb_read_data, g.rdata);
            check("rd", 32'(o_m_wb_rd), 32'(g.rd));
            check("mem_to_reg", 32'(o_m_wb_mem_to_reg), 32'(g.m2r));
            check("reg_write", 32'(o_m_wb_reg_write), 32'(g.rw));
            check("data_write", o_m_wb_data_write, g.dw);
            check("misaligned", 32'(mis_obs), 32'(g.mis));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_alu"}, o_m_wb_alu_result, 32'h0);
        check({tag, "_rdata"}, o_m_wb_read_data, 32'h0);
        check({tag, "_rd"}, 32'(o_m_wb_rd), 32'h0);
        check({tag, "_m2r"}, 32'(o_m_wb_mem_to_reg), 32'h0);
        check({tag, "_rw"}, 32'(o_m_wb_reg_write), 32'h0);
        check({tag, "_dw"}, o_m_wb_data_write, 32'h0);
        check({tag, "_mis"}, 32'(mis_obs), 32'h0);
    endtask

    initial begin
        logic [31:0] r;
        // Reset state.
        repeat (2) @(posedge i_clk);
        #1;
        check_zero_outputs("reset");
        i_reset = 1'b1;

        // Fill memory so every later load has a known expected value.
        for (int i = 0; i < DEPTH; i++) begin
            step(32'(i * 4), 32'hA500_0000 + 32'(i), 5'(i), 1'b0, 1'b1, 1'b0, 1'b0);
        end

        // Store then load.
        step(32'h10, 32'hDEADBEEF, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(32'h10, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        check("st_ld_data_write", o_m_wb_data_write, 32'hDEADBEEF);

        // ALU passthrough.
        step(32'd5, 32'h0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        check("passthru_dw", o_m_wb_data_write, 32'd5);

        // Address wrap.
        step(32'h100, 32'h1234, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        dbg_check("wrap_dbg0", '0, 32'h1234);
        step(32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        check("wrap_load", o_m_wb_read_data, 32'h1234);

        // Simultaneous read/write returns the old word.
        step(32'h20, 32'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(32'h20, 32'd9, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        check("rw_old", o_m_wb_read_data, 32'd7);
        step(32'h20, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
        check("rw_new", o_m_wb_read_data, 32'd9);

        // Random aligned traffic with arbitrary upper address bits.
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            step({r[31:2], 2'b00}, $urandom, 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset mid-operation: outputs clear immediately, memory untouched,
        // and a store presented while reset is held must not land.
        step(32'h10, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        i_reset = 1'b0;
        #1;
        check_zero_outputs("midrst");
        dbg_check("midrst_dbg", 6'd4, model[4]);
        i_ex_m_alu_result = 32'h10;
        i_ex_m_write_data = 32'h5555_AAAA;
        i_ex_m_mem_write  = 1'b1;
        i_ex_m_mem_read   = 1'b0;
        @(posedge i_clk);
        #1;
        dbg_check("rst_store_blocked", 6'd4, model[4]);
        check_zero_outputs("held_rst");
        i_ex_m_mem_write = 1'b0;
        i_reset = 1'b1;
        step(32'h10, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
        step(32'h44, 32'h0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef MEM_MISALIGN_TRAP_EN
        // Misaligned store is trapped.
        step(32'h22, 32'hFF, 5'd10, 1'b0, 1'b1, 1'b0, 1'b1);
        check("trap_flag", 32'(o_misaligned), 32'd1);
        check("trap_rw", 32'(o_m_wb_reg_write), 32'd0);
        dbg_check("trap_word", 6'd8, model[8]);
        step(32'h23, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1);
        step(32'h20, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1);
`else
        // Low address bits are ignored without the trap.
        step(32'h22, 32'hFF, 5'd10, 1'b0, 1'b1, 1'b0, 1'b1);
        dbg_check("noalign_word", 6'd8, 32'hFF);
        step(32'h23, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1);
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/m_stage.md
M_STAGE -- requirements
Module: m_stage

Interface
- REQ-001 Parameter: ADDR_W, 6, word-address width; data memory depth = 2^ADDR_W 32-bit words.
- REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
- REQ-003 i_clk  in  1  clock; all state updates on rising edge.
- REQ-004 i_reset  in  1  asynchronous, active-low reset.
- REQ-005 i_ex_m_alu_result  in  32  byte address for loads/stores; ALU result otherwise.
- REQ-006 i_ex_m_write_data  in  32  store data.
- REQ-007 i_ex_m_rd  in  5  destination register.
- REQ-008 i_ex_m_mem_read / i_ex_m_mem_write / i_ex_m_mem_to_reg / i_ex_m_reg_write  in  1 each  control from EX/M register.
- REQ-009 i_dbg_addr  in  ADDR_W  debug word address.
- REQ-010 o_dbg_data  out  32  memory word at i_dbg_addr.
- REQ-011 o_m_wb_alu_result / o_m_wb_read_data  out  32 each  registered M/WB payload.
- REQ-012 o_m_wb_rd  out  5 and o_m_wb_mem_to_reg / o_m_wb_reg_write  out  1 each  registered M/WB control.
- REQ-013 o_m_wb_data_write  out  32  writeback value, forwarded to EX.
- REQ-014 o_misaligned  out  1  registered flag for a misaligned access; present only with MEM_MISALIGN_TRAP_EN.

Function
- REQ-015 Word index SHALL be i_ex_m_alu_result[ADDR_W+1:2]; higher bits are ignored, so addresses wrap modulo 2^(ADDR_W+2).
- REQ-016 When i_ex_m_mem_write=1, mem[index] SHALL take i_ex_m_write_data at the rising edge.
- REQ-017 At each rising edge, o_m_wb_read_data SHALL take mem[index] if i_ex_m_mem_read=1, else 0 (one-cycle latency).
- REQ-018 If mem_read and mem_write are both 1, the write SHALL occur and o_m_wb_read_data SHALL return the old contents (read-before-write).
- REQ-019 At each rising edge, o_m_wb_alu_result, o_m_wb_rd, o_m_wb_mem_to_reg and o_m_wb_reg_write SHALL take their i_ex_m_* inputs unchanged.
- REQ-020 o_m_wb_data_write SHALL be combinational: o_m_wb_read_data if o_m_wb_mem_to_reg=1, else o_m_wb_alu_result.
- REQ-021 o_dbg_data SHALL be a combinational read of mem[i_dbg_addr], including writes committed on the previous edge.
- REQ-022 A store followed back-to-back by a load to the same address SHALL return the stored data.
- REQ-023 There is no stall or flush input; the stage advances every cycle.

Reset
- REQ-024 While i_reset=0, all registered M/WB outputs and o_misaligned SHALL be 0 immediately, without waiting for a clock edge.
- REQ-025 Memory contents SHALL NOT be changed by reset.
- REQ-026 A store with reset asserted at its edge SHALL NOT write memory.
- REQ-027 The first edge after deassertion SHALL operate normally.

Configuration
- REQ-028 Macro MEM_MISALIGN_TRAP_EN SHALL control misaligned-access handling.
- REQ-029 With MEM_MISALIGN_TRAP_EN defined, an access (mem_read or mem_write) with alu_result[1:0]!=0 SHALL:
  - suppress the memory write;
  - force o_m_wb_reg_write to 0;
  - set o_misaligned to 1 for that cycle (0 otherwise).
- REQ-030 With MEM_MISALIGN_TRAP_EN undefined:
  - alu_result[1:0] SHALL be ignored;
  - the o_misaligned port SHALL be absent.

Verification
- REQ-031 Store then load: store 0xDEADBEEF to 0x10, then load 0x10 with mem_to_reg=1 -> o_m_wb_data_write = 0xDEADBEEF one edge after the load.
- REQ-032 ALU passthrough: alu_result=5, rd=9, reg_write=1, mem_to_reg=0 -> after one edge, o_m_wb_data_write=5, o_m_wb_rd=9, o_m_wb_reg_write=1.
- REQ-033 Wrap: ADDR_W=6, store 0x1234 to 0x100, then load 0x0 -> read returns 0x1234; o_dbg_data at address 0 = 0x1234.
- REQ-034 Simultaneous read/write: address 0x20 holds 7, both mem_read and mem_write=1 with data 9 -> read returns 7; next load returns 9.
- REQ-035 Reset mid-operation: drop i_reset between edges -> all M/WB outputs 0 immediately; memory word previously written unchanged via o_dbg_data.
- REQ-036 MEM_MISALIGN_TRAP_EN defined: store 0xFF to 0x22 -> o_misaligned=1, o_m_wb_reg_write=0, word 0x20 unchanged.
